// File: rtl/uop_pkg.sv
// Shared types and constants for the microcode sequencer: RV32I opcodes,
// per-opcode microcode base addresses and field-use flags, FSM states.
package uop_pkg;

  // RV32I major opcodes recognised by the sequencer
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  // Microcode routine base addresses
  localparam logic [7:0] BASE_NOP    = 8'h00;
  localparam logic [7:0] BASE_BRANCH = 8'h01;
  localparam logic [7:0] BASE_LUI    = 8'h03;
  localparam logic [7:0] BASE_AUIPC  = 8'h04;
  localparam logic [7:0] BASE_LOAD   = 8'h09;
  localparam logic [7:0] BASE_JAL    = 8'h0C;
  localparam logic [7:0] BASE_STORE  = 8'h0F;
  localparam logic [7:0] BASE_OP_IMM = 8'h12;
  localparam logic [7:0] BASE_OP     = 8'h1B;
  localparam logic [7:0] BASE_JALR   = 8'h24;

  // One row of the opcode table: is it known, where does it start,
  // does func3 offset the address, does func7[5] add 8
  typedef struct packed {
    logic       known;
    logic [7:0] base;
    logic       use_f3;
    logic       use_f7;
  } map_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ISSUE = 2'd2
  } seq_state_e;

  // The LAST flag is the top bit of a microcode word
  function automatic int uop_last_bit(input int word_w);
    return word_w - 1;
  endfunction

  function automatic map_entry_t lookup_opcode(input logic [6:0] opc);
    map_entry_t e;
    e = '{known: 1'b0, base: BASE_NOP, use_f3: 1'b0, use_f7: 1'b0};
    case (opc)
      OPC_LUI:    e = '{1'b1, BASE_LUI,    1'b0, 1'b0};
      OPC_AUIPC:  e = '{1'b1, BASE_AUIPC,  1'b0, 1'b0};
      OPC_JAL:    e = '{1'b1, BASE_JAL,    1'b0, 1'b0};
      OPC_JALR:   e = '{1'b1, BASE_JALR,   1'b0, 1'b0};
      OPC_BRANCH: e = '{1'b1, BASE_BRANCH, 1'b1, 1'b0};
      OPC_LOAD:   e = '{1'b1, BASE_LOAD,   1'b1, 1'b0};
      OPC_STORE:  e = '{1'b1, BASE_STORE,  1'b1, 1'b0};
      OPC_OP_IMM: e = '{1'b1, BASE_OP_IMM, 1'b1, 1'b0};
      OPC_OP:     e = '{1'b1, BASE_OP,     1'b1, 1'b1};
      default:    ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rom.sv
// Microcode ROM with a one-cycle registered read. Routine layout:
// 0x00-0x08 single-word, 0x09-0x11 LAST on odd addresses, 0x12-0x14 a
// three-word routine, 0x15-0x1A single-word, everything above has no LAST
// (those routines end only by the step limit).
module rom #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = DW - 1;

  logic [DW-1:0] rom_mem [DEPTH];
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  function automatic logic [DW-1:0] rom_word(input int a);
    logic          last;
    logic [PW-1:0] payload;
    if (a <= 8)        last = 1'b1;
    else if (a <= 17)  last = a[0];
    else if (a <= 19)  last = 1'b0;
    else if (a <= 26)  last = 1'b1;
    else               last = 1'b0;
    payload = PW'(64'(a) * 64'h9E37_79B1);
    return {last, payload};
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_mem[gi] = rom_word(gi);
  end

  // Address lookup feeding the read register
  always_comb begin
    data_d = rom_mem[addr];
  end

  // Synchronous read port
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/uop_addr_map.sv
// Combinational decode of an RV32I instruction into a microcode base
// address plus an illegal flag. Illegal instructions map to the no-op
// routine at address 0.
module uop_addr_map
  import uop_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int UADDR_W = 6
) (
  input  logic [XLEN-1:0]    instruction,
  output logic [UADDR_W-1:0] uaddr,
  output logic               illegal
);

  // Wide enough for a carry out of UADDR_W bits and for the 8-bit bases
  localparam int SUM_W = (UADDR_W + 1 > 9) ? UADDR_W + 1 : 9;

  map_entry_t       entry;
  logic [SUM_W-1:0] wide_sum;
  logic             overflow;

  // Base + func3 (+8 for func7[5]); anything that spills past UADDR_W is illegal
  always_comb begin
    entry    = lookup_opcode(instruction[6:0]);
    wide_sum = SUM_W'(entry.base);
    if (entry.use_f3) wide_sum = wide_sum + SUM_W'(instruction[14:12]);
    if (entry.use_f7) wide_sum = wide_sum + SUM_W'({instruction[30], 3'b000});
    overflow = |wide_sum[SUM_W-1:UADDR_W];
    illegal  = ~entry.known | overflow;
    uaddr    = illegal ? '0 : wide_sum[UADDR_W-1:0];
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Accepts one RV32I instruction per handshake, looks up its microcode
// routine and issues the routine one word at a time to execute. Routines
// are cut short at MAX_UOPS steps or at the top of the ROM.
module microcode_sequencer
  import uop_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int UADDR_W  = 6,
  parameter int UWORD_W  = 32,
  parameter int MAX_UOPS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [XLEN-1:0]    instruction,
  output logic               uop_valid,
  input  logic               uop_ready,
  output logic [UWORD_W-1:0] microcode,
  output logic [UADDR_W-1:0] uop_addr,
  output logic               uop_last,
  output logic [24:0]        instruction_data,
  output logic               illegal,
  output logic               seq_fault
);

  localparam int CNT_W    = $clog2(MAX_UOPS) + 1;
  localparam int LAST_BIT = uop_last_bit(UWORD_W);

  seq_state_e         state_q, state_d;
  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [24:0]        idata_q, idata_d;
  logic               illegal_q, illegal_d;

  logic [UADDR_W-1:0] map_uaddr;
  logic               map_illegal;
  logic               accept;
  logic               issue;
  logic               rom_last;
  logic               forced;

  uop_addr_map #(
    .XLEN    (XLEN),
    .UADDR_W (UADDR_W)
  ) u_addr_map (
    .instruction (instruction),
    .uaddr       (map_uaddr),
    .illegal     (map_illegal)
  );

  rom #(
    .AW (UADDR_W),
    .DW (UWORD_W)
  ) u_rom (
    .clk  (clk),
    .addr (uaddr_q),
    .data (microcode)
  );

  assign instr_ready      = (state_q == ST_IDLE) & ~rst;
  assign accept           = instr_valid & instr_ready;
  assign issue            = (state_q == ST_ISSUE);
  assign rom_last         = microcode[LAST_BIT];
  // Force an end on the final allowed step or when the next address would wrap
  assign forced           = (count_q == CNT_W'(MAX_UOPS - 1)) | (&uaddr_q);
  assign uop_valid        = issue;
  assign uop_last         = issue & (rom_last | forced);
  assign seq_fault        = issue & forced & ~rom_last;
  assign uop_addr         = uaddr_q;
  assign instruction_data = idata_q;
  assign illegal          = illegal_q;

  // Next-state and datapath updates for IDLE -> READ -> ISSUE stepping
  always_comb begin
    state_d   = state_q;
    uaddr_d   = uaddr_q;
    count_d   = count_q;
    idata_d   = idata_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idata_d   = instruction[31:7];
          uaddr_d   = map_uaddr;
          illegal_d = map_illegal;
          count_d   = '0;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (uop_ready) begin
          if (uop_last) begin
            state_d = ST_IDLE;
          end else begin
            uaddr_d = uaddr_q + UADDR_W'(1);
            count_d = count_q + CNT_W'(1);
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any routine in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      uaddr_q   <= '0;
      count_q   <= '0;
      idata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      uaddr_q   <= uaddr_d;
      count_q   <= count_d;
      idata_q   <= idata_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
Parametrised successor to the single-cycle instruction decoder: it accepts one RV32I instruction per valid/ready handshake and maps its opcode, func3 and func7 to a microcode base address. It then steps through a multi-word microcode routine, issuing one micro-op at a time to the execute stage under its own valid/ready handshake. It sits between instruction fetch and the datapath and owns the microcode ROM instance. It adds illegal-instruction detection, backpressure and a runaway-routine guard.

Parameters:
XLEN, 32, instruction width (fields at standard RV32 positions)
UADDR_W, 6, microcode address width; ROM depth = 2**UADDR_W
UWORD_W, 32, microcode word width; bit UWORD_W-1 is the LAST flag
MAX_UOPS, 8, maximum micro-ops per instruction before a forced end

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept; = (state==IDLE) & ~rst
instruction  in  XLEN  instruction word, sampled on accept
uop_valid  out  1  microcode/uop_* outputs valid
uop_ready  in  1  execute consumes current micro-op
microcode  out  UWORD_W  current microcode word (ROM data)
uop_addr  out  UADDR_W  address of current microcode word
uop_last  out  1  final micro-op of this instruction
instruction_data  out  25  instruction[31:7] of the accepted instruction, held for the whole routine
illegal  out  1  accepted instruction was illegal; held for the whole routine
seq_fault  out  1  routine truncated by MAX_UOPS or address wrap; valid with uop_last

Behaviour:
- Reset (async, any state including mid-routine): state=IDLE, uop_valid=0, illegal=0, seq_fault=0, instruction_data=0, uaddr_q=0, step count=0. The in-flight routine is discarded.
- FSM states are IDLE, READ and ISSUE.
- IDLE: on instr_valid & instr_ready, register instruction[31:7], the computed base address into uaddr_q, and the illegal flag; clear step count; go to READ.
- READ: the ROM (synchronous read, 1 cycle) samples uaddr_q; go to ISSUE.
- ISSUE: uop_valid=1. microcode, uop_addr, uop_last, illegal and seq_fault are stable while uop_ready=0.
  - On handshake with uop_last=1: go to IDLE.
  - On handshake with uop_last=0: uaddr_q+1, count+1, go to READ.
- Latency: an instruction accepted in cycle N gives its first uop_valid in cycle N+2. Each subsequent micro-op follows 2 cycles after the previous handshake. instr_ready returns 1 in the cycle after the last handshake.
- uop_last = microcode[UWORD_W-1] | forced.
  - forced=1 when step count == MAX_UOPS-1, or when uaddr_q is all-ones (the next address would wrap).
  - seq_fault = forced & ~microcode[UWORD_W-1].
- Address map, on instruction[6:0]; bits [1:0] must equal 2'b11:
  - LUI 0110111 -> 0x03; AUIPC 0010111 -> 0x04; JAL 1101111 -> 0x0C; JALR 1100111 -> 0x24.
  - BRANCH 1100011 -> 0x01+f3; LOAD 0000011 -> 0x09+f3; STORE 0100011 -> 0x0F+f3; OP-IMM 0010011 -> 0x12+f3.
  - OP 0110011 -> 0x1B+f3+8*instruction[30].
  - f3 = instruction[14:12].
- Width rule: the sum is computed in UADDR_W+1 bits. A carry out of UADDR_W bits is illegal.
- Illegal cases: unknown opcode, bits [1:0] != 11, or address overflow. All map to address 0x00 (no-op routine) with illegal=1. The instruction is still consumed normally, never stalled.
- instr_valid while not ready: ignored; the upstream holds the instruction.

Decomposition:
- Package uop_pkg:
  - opcode enum (7-bit RV32I opcodes)
  - base-address constants and use-func3/use-func7 flags per opcode
  - LAST bit index
  - FSM state enum
- Sub-module uop_addr_map: combinational instruction -> {uaddr, illegal}. It is reused by the bench as a reference.
- The existing rom module is instantiated with addr = uaddr_q.

Test Plan:
- LUI 0x000012B7, ROM[0x03] has LAST set, uop_ready=1 -> uop_valid cycle N+2, uop_addr=0x03, instruction_data=0x0000025, uop_last=1, instr_ready=1 at N+3.
- ADD 0x003100B3 then SUB 0x403100B3 -> uop_addr 0x1B, then uop_addr 0x23; BNE 0x00209463 -> uop_addr 0x02.
- Instruction 0x00000000 and opcode 0x7F -> illegal=1, uop_addr=0x00, single uop, sequencer returns to IDLE.
- 3-word routine at 0x12 (LAST only on 0x14), uop_ready low 3 cycles at each ISSUE -> outputs stable while stalled; addresses 0x12, 0x13, 0x14 in order; uop_last only on 0x14.
- Routine with no LAST bit, MAX_UOPS=8 -> 8th micro-op has uop_last=1 and seq_fault=1; next instruction accepted.
- rst pulsed during READ of the 2nd micro-op (async, mid-cycle) -> uop_valid=0 immediately, instr_ready=1 after release, next instruction decodes from its own base address.
